twoscomplement_rx: RTL and testbench
====================================

Name: twoscomplement_rx

Overview:
Receive end of the team's bit-serial two's-complement link. It accepts WIDTH-bit two's-complement words serially, LSB first, one bit per accepted cycle. It deserializes each word and presents it in parallel as sign-magnitude, with a valid/ready output handshake. Negation is done bit-serially during reception using the same inverted-bit-plus-carry scheme as the transmit side, so no parallel adder is needed.

Parameters:
WIDTH, 8, bits per serial word (>=2); also the out_mag width

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  in_bit carries a valid serial bit this cycle
in_bit  input  1  serial data, LSB first; the last bit of a word is the sign
in_ready  output  1  receiver can accept a bit this cycle
out_valid  output  1  out_sign/out_mag hold a complete word
out_ready  input  1  downstream accepts the word
out_sign  output  1  1 = negative
out_mag  output  WIDTH  unsigned magnitude

Behaviour:
- Reset: applied asynchronously while reset=0.
  - State=RECV, bit counter=0, carry=1, raw/neg shift registers=0.
  - Outputs: in_ready=1, out_valid=0, out_sign=0, out_mag=0.
- Bit acceptance: a bit is accepted when in_valid && in_ready. Cycles with in_valid=0 are gaps; all state holds.
- Per accepted bit k (k = counter, 0..WIDTH-1):
  - raw[k] <= in_bit
  - neg[k] <= !in_bit ^ carry
  - carry <= !in_bit & carry
  - counter increments.
- Frame start (k=0) always uses carry=1. The carry is reloaded to 1 whenever the counter wraps.
- State RECV: in_ready=1, out_valid=0.
  - Accepting bit k=WIDTH-1 moves to HOLD on the next edge.
  - On that edge: out_sign <= in_bit; out_mag <= in_bit ? neg_final : raw_final.
  - raw_final/neg_final include the bit being accepted in that cycle.
  - Counter returns to 0 and carry returns to 1.
- Latency: out_valid rises on the first edge after the last bit is accepted (1 cycle).
- State HOLD: out_valid=1, in_ready=0. out_sign/out_mag stay stable until the handshake.
  - out_valid && out_ready moves to RECV on the next edge; out_valid drops and in_ready rises.
  - No bit is accepted in the handshake cycle, because in_ready=0 in HOLD.
- Arithmetic:
  - The most-negative word -2^(WIDTH-1) gives out_sign=1, out_mag=2^(WIDTH-1). This fits WIDTH bits, so there is no overflow flag.
  - Word 0 gives out_sign=0, out_mag=0. Negative zero is never produced.
- out_mag/out_sign keep their last value after the handshake and update only at the next word's completion.
- Reset mid-frame or mid-HOLD discards partial and held data and returns to the reset state.
- in_bit is ignored while in_valid=0 or in_ready=0.

Optional Feature:
Macro TWOSCOMPLEMENT_RX_CLEAR_EN.
- Defined:
  - Adds input port clear (1 bit, synchronous, active-high, highest priority after reset).
  - clear=1 at a clock edge forces the reset state (RECV, counter 0, carry 1, out_valid 0, out_sign 0, out_mag 0).
  - Any bit presented in that cycle is dropped.
  - Used by the link controller to resynchronise framing.
- Not defined: port clear is absent. Framing recovers only through reset.

Test Plan:
- WIDTH=8, stream 0x05 LSB first (1,0,1,0,0,0,0,0), in_valid held 1, out_ready=1 -> one cycle after bit 7: out_valid=1, out_sign=0, out_mag=0x05; in_ready=0 for exactly that cycle.
- Stream 0xFB (-5) (1,1,0,1,1,1,1,1) -> out_sign=1, out_mag=0x05. Stream 0x80 -> out_sign=1, out_mag=0x80. Stream 0xFF -> sign 1, mag 0x01. Stream 0x00 -> sign 0, mag 0x00.
- Stream 0xFB with in_valid deasserted for 2 cycles after bits 2 and 5 -> same result as the first 0xFB case; out_valid 1 cycle after the final accepted bit.
- Word complete with out_ready=0 for 4 cycles, in_valid=1 and toggling in_bit -> out_valid/out_sign/out_mag stable, in_ready=0 throughout. After out_ready=1: out_valid=0 next cycle, and the next word decodes correctly from bit 0.
- Reset driven to 0 asynchronously (mid-clock) after 3 bits of 0xFB, then stream 0x05 -> outputs 0 during reset, then sign 0, mag 0x05 (no corruption from the partial frame).
- With TWOSCOMPLEMENT_RX_CLEAR_EN: clear pulsed after 5 bits, then stream 0x81 -> sign 1, mag 0x7F. Without the macro: the bench compiles with no clear port.

Source files
------------

// File: rtl/twoscomplement_rx.sv
// twoscomplement_rx: bit-serial two's-complement receiver.
// Deserializes WIDTH-bit words (LSB first, last bit is the sign) and presents
// them as sign-magnitude behind a valid/ready output handshake. The negated
// value is built bit-serially alongside the raw bits (inverted bit plus a
// rippling carry), so no parallel adder is needed at word completion.
// Optional macro TWOSCOMPLEMENT_RX_CLEAR_EN adds a synchronous 'clear' input
// that forces the idle state so the link controller can resynchronise framing.
module twoscomplement_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] raw_reg;
  logic [WIDTH-1:0] neg_reg;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] neg_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             out_sign_reg;
  logic [WIDTH-1:0] out_mag_reg;
  logic             accept;
  logic             last_bit;
  logic             carry_next;
  logic             sync_clear;

`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
  assign sync_clear = clear;
`else
  assign sync_clear = 1'b0;
`endif

  assign accept     = in_valid && in_ready_reg;
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign carry_next = ~in_bit & carry_reg;

  // Per-bit slot update: only the slot selected by the counter takes the new
  // bit, so raw_next/neg_next already include the bit accepted this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign raw_next[gi] = (accept && cnt_reg == CW'(gi)) ? in_bit : raw_reg[gi];
      assign neg_next[gi] = (accept && cnt_reg == CW'(gi)) ? (~in_bit ^ carry_reg) : neg_reg[gi];
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sign  = out_sign_reg;
  assign out_mag   = out_mag_reg;

  // Receive FSM: shift in bits in RECV, present the decoded word in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RECV;
      cnt_reg       <= '0;
      carry_reg     <= 1'b1;
      raw_reg       <= '0;
      neg_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_sign_reg  <= 1'b0;
      out_mag_reg   <= '0;
    end else if (sync_clear) begin
      state_reg     <= RECV;
      cnt_reg       <= '0;
      carry_reg     <= 1'b1;
      raw_reg       <= '0;
      neg_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_sign_reg  <= 1'b0;
      out_mag_reg   <= '0;
    end else begin
      case (state_reg)
        RECV: begin
          if (accept) begin
            raw_reg <= raw_next;
            neg_reg <= neg_next;
            if (last_bit) begin
              // Sign bit arrives last: pick the magnitude source it selects.
              state_reg     <= HOLD;
              cnt_reg       <= '0;
              carry_reg     <= 1'b1;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_sign_reg  <= in_bit;
              out_mag_reg   <= in_bit ? neg_next : raw_next;
            end else begin
              cnt_reg   <= cnt_reg + CW'(1);
              carry_reg <= carry_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= RECV;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= RECV;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twoscomplement_rx.sv
// tb_twoscomplement_rx: directed, table-driven bench for twoscomplement_rx.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// Define TWOSCOMPLEMENT_RX_CLEAR_EN to also exercise the clear port.
module tb_twoscomplement_rx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
  logic             clear;
`endif

  int errors = 0;
  int checks = 0;

  twoscomplement_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
    .clear     (clear),
`endif
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       exp_sign;
    logic [7:0] exp_mag;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serially send one word; gap_mask[k] inserts two idle cycles after bit k.
  // Returns at the falling edge right after the last bit was clocked in.
  task automatic send_word(input logic [7:0] w, input logic [7:0] gap_mask);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      chk($sformatf("out_valid_low_bit%0d", k), {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      in_bit   = w[k];
      if (gap_mask[k]) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_bit   = ~in_bit;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic check_word(input string name, input logic s, input logic [7:0] m);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_sign"},  {31'd0, out_sign}, {31'd0, s});
    chk({name, "_mag"},   {24'd0, out_mag},  {24'd0, m});
  endtask

  task automatic check_idle(input string name);
    chk({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
    clear     = 1'b0;
`endif

    vecs[0] = '{8'h05, 1'b0, 8'h05};
    vecs[1] = '{8'hFB, 1'b1, 8'h05};
    vecs[2] = '{8'h80, 1'b1, 8'h80};
    vecs[3] = '{8'hFF, 1'b1, 8'h01};
    vecs[4] = '{8'h00, 1'b0, 8'h00};
    vecs[5] = '{8'h7F, 1'b0, 8'h7F};
    vecs[6] = '{8'h81, 1'b1, 8'h7F};
    vecs[7] = '{8'h01, 1'b0, 8'h01};

    // Reset state
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sign",  {31'd0, out_sign},  32'd0);
    chk("rst_out_mag",   {24'd0, out_mag},   32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven words, out_ready held high
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].word, 8'h00);
      check_word($sformatf("vec%0d_%02h", i, vecs[i].word), vecs[i].exp_sign, vecs[i].exp_mag);
      in_valid = 1'b0;
      @(negedge clk);
      check_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mag_kept", i), {24'd0, out_mag}, {24'd0, vecs[i].exp_mag});
      $display("word 0x%02h -> sign=%0d mag=0x%02h", vecs[i].word, out_sign, out_mag);
    end

    // 0xFB with two-cycle gaps after bits 2 and 5
    send_word(8'hFB, 8'b0010_0100);
    check_word("gap_FB", 1'b1, 8'h05);
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("gap_FB");
    $display("gapped 0xFB -> sign=%0d mag=0x%02h", out_sign, out_mag);

    // Backpressure: 4 cycles with out_ready low while bits keep arriving
    out_ready = 1'b0;
    send_word(8'h05, 8'h00);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      check_word($sformatf("bp_hold%0d", c), 1'b0, 8'h05);
      in_valid = 1'b1;
      in_bit   = c[0];
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("bp_release");
    send_word(8'hFB, 8'h00);
    check_word("bp_next_FB", 1'b1, 8'h05);
    in_valid = 1'b0;
    @(negedge clk);
    $display("backpressure -> next word sign=%0d mag=0x%02h", out_sign, out_mag);

    // Asynchronous reset after 3 bits of 0xFB
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = (k == 2) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_sign",  {31'd0, out_sign},  32'd0);
    chk("arst_out_mag",   {24'd0, out_mag},   32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    send_word(8'h05, 8'h00);
    check_word("arst_then_05", 1'b0, 8'h05);
    in_valid = 1'b0;
    @(negedge clk);
    $display("after reset 0x05 -> sign=%0d mag=0x%02h", out_sign, out_mag);

`ifdef TWOSCOMPLEMENT_RX_CLEAR_EN
    // Clear after 5 bits, then 0x81
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = k[0];
    end
    @(negedge clk);
    clear  = 1'b1;
    in_bit = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check_idle("clr");
    chk("clr_out_mag", {24'd0, out_mag}, 32'd0);
    send_word(8'h81, 8'h00);
    check_word("clr_then_81", 1'b1, 8'h7F);
    in_valid = 1'b0;
    @(negedge clk);
    $display("after clear 0x81 -> sign=%0d mag=0x%02h", out_sign, out_mag);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
